// File: rtl/alpha_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alpha_seq_if
//  Description : Bundle between the decoder schedule FSM, the alpha layer
//                store / node-processor array, and alpha_seq_ctrl.
//                master : the sequencer view (takes start, drives the store
//                         read/write beats and status).
//                slave  : the environment view (schedule FSM plus store).
//  Signals     : start, layer_start[4:0], layer_stop[4:0], g_mode  (request)
//                busy, done, err                                   (status)
//                r_en, layer_r[4:0], cntb[4:0]                     (read)
//                pe_vld, pe_g                                      (node proc)
//                w_en, layer_w[4:0], cnta[5:0]                     (write)
//  Revision    : 1.0  initial release
// ============================================================================
interface alpha_seq_if;
    logic       start;
    logic [4:0] layer_start;
    logic [4:0] layer_stop;
    logic       g_mode;
    logic       busy;
    logic       done;
    logic       err;
    logic       r_en;
    logic [4:0] layer_r;
    logic [4:0] cntb;
    logic       pe_vld;
    logic       pe_g;
    logic       w_en;
    logic [4:0] layer_w;
    logic [5:0] cnta;

    modport master (
        input  start, layer_start, layer_stop, g_mode,
        output busy, done, err,
        output r_en, layer_r, cntb,
        output pe_vld, pe_g,
        output w_en, layer_w, cnta
    );

    modport slave (
        output start, layer_start, layer_stop, g_mode,
        input  busy, done, err,
        input  r_en, layer_r, cntb,
        input  pe_vld, pe_g,
        input  w_en, layer_w, cnta
    );
endinterface
`default_nettype wire

// File: rtl/alpha_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alpha_seq_ctrl
//  Description : Alpha (LLR) layer-store sequencer for the SCAN decoder.
//                Walks one descent from layer_start down to layer_stop,
//                issuing read beats per layer, tagging the f/g operation,
//                and issuing the matching write beats into the next-lower
//                layer RD_LAT cycles later.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                sq     - alpha_seq_if.master (request, status, read beats,
//                         node-processor tag, write beats)
//  Parameters  : P      - elements per beat / half-layer chunk per read
//                PE_LAT - store read-data valid to processed data valid
//                LMAX   - top layer index (log2 N)
//  Revision    : 1.0  initial release
// ============================================================================
module alpha_seq_ctrl #(
    parameter int P      = 32,
    parameter int PE_LAT = 2,
    parameter int LMAX   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    alpha_seq_if.master sq
);

    localparam int              RD_LAT     = 1 + PE_LAT;
    localparam int              LOG_P      = $clog2(P);
    localparam int              DW         = $clog2(RD_LAT + 1);
    localparam logic [4:0]      LMAX_L     = 5'(LMAX);
    localparam logic [DW-1:0]   DRAIN_INIT = DW'(RD_LAT);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // One in-flight beat on its way from the read port to the write port.
    typedef struct packed {
        logic       vld;
        logic [4:0] layer;
        logic [4:0] beat;
    } stage_t;

    state_t        r_state;
    logic [4:0]    r_cur;
    logic [4:0]    r_stop;
    logic [4:0]    r_last;     // last beat index of the layer being read
    logic          r_gflag;
    logic [DW-1:0] r_drain;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_rd_en;
    logic [4:0]    r_layer_r;
    logic [4:0]    r_cntb;
    logic          r_pe_g;
    stage_t        r_pipe [RD_LAT];

    logic [4:0]    w_next_layer;
    logic          w_start_bad;

    assign w_next_layer = r_cur - 5'd1;
    assign w_start_bad  = (sq.layer_start > LMAX_L) ||
                          (sq.layer_stop == 5'd0) ||
                          (sq.layer_start <= sq.layer_stop);

    // Last beat index of a layer: a layer holds 2^(L-1) elements per half,
    // fetched P at a time, with a single beat once a half fits in one beat.
    function automatic logic [4:0] last_beat(input logic [4:0] layer);
        int half_log;
        int nbeat;
        half_log = int'(layer) - 1;
        if (half_log <= LOG_P)
            nbeat = 1;
        else
            nbeat = 1 << (half_log - LOG_P);
        return 5'(nbeat - 1);
    endfunction

    // ------------------------------------------------------------------
    // Descent FSM. All outputs are registered; the first read beat is
    // issued on the same edge that accepts start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cur     <= 5'd0;
            r_stop    <= 5'd0;
            r_last    <= 5'd0;
            r_gflag   <= 1'b0;
            r_drain   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_layer_r <= 5'd0;
            r_cntb    <= 5'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sq.start) begin
                        if (w_start_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cur     <= sq.layer_start;
                            r_stop    <= sq.layer_stop;
                            r_gflag   <= sq.g_mode;
                            r_last    <= last_beat(sq.layer_start);
                            r_busy    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            r_layer_r <= sq.layer_start;
                            r_cntb    <= 5'd0;
                            r_state   <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (r_cntb == r_last) begin
                        r_rd_en   <= 1'b0;
                        r_layer_r <= 5'd0;
                        r_cntb    <= 5'd0;
                        r_drain   <= DRAIN_INIT;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_cntb <= r_cntb + 5'd1;
                    end
                end

                S_DRAIN: begin
                    // Waiting out RD_LAT cycles lets the last write into
                    // cur-1 land before cur-1 is read as the next source.
                    if (r_drain == DRAIN_LAST) begin
                        if (w_next_layer > r_stop) begin
                            r_cur     <= w_next_layer;
                            r_gflag   <= 1'b0;
                            r_last    <= last_beat(w_next_layer);
                            r_rd_en   <= 1'b1;
                            r_layer_r <= w_next_layer;
                            r_cntb    <= 5'd0;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_drain <= r_drain - DRAIN_LAST;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write pipeline. Shifts every cycle regardless of the FSM so each
    // issued read produces exactly one write RD_LAT cycles later. The g
    // tag is only needed at the node-processor input, so it is carried
    // one stage only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pe_g <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pe_g         <= r_rd_en & r_gflag;
            r_pipe[0].vld   <= r_rd_en;
            r_pipe[0].layer <= r_rd_en ? (r_layer_r - 5'd1) : 5'd0;
            r_pipe[0].beat  <= r_cntb;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign sq.busy    = r_busy;
    assign sq.done    = r_done;
    assign sq.err     = r_err;
    assign sq.r_en    = r_rd_en;
    assign sq.layer_r = r_layer_r;
    assign sq.cntb    = r_cntb;
    assign sq.pe_vld  = r_pipe[0].vld;
    assign sq.pe_g    = r_pe_g;
    assign sq.w_en    = r_pipe[RD_LAT-1].vld;
    assign sq.layer_w = r_pipe[RD_LAT-1].layer;
    assign sq.cnta    = {1'b0, r_pipe[RD_LAT-1].beat};

endmodule
`default_nettype wire
